// File: rtl/dht11_sensor_emu.sv
// rtl/dht11_sensor_emu.sv - DHT11 device-side responder (sensor emulator) for the single-wire data line
module dht11_sensor_emu #(
    parameter int US_CYC       = 25,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_in,
    output logic       o_data_oe,
    input  logic [7:0] i_humidity_int,
    input  logic [7:0] i_humidity_float,
    input  logic [7:0] i_temperature_int,
    input  logic [7:0] i_temperature_float,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_abort
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int START_CYC = START_MIN_US * US_CYC;
    localparam int MAX_US    = max_of(max_of(max_of(RESP_WAIT_US, RESP_LOW_US), max_of(RESP_HIGH_US, BIT_LOW_US)),
                                      max_of(BIT0_HIGH_US, BIT1_HIGH_US));
    localparam int CNT_W     = $clog2(max_of(START_CYC, MAX_US * US_CYC) + 1);

    localparam logic [CNT_W-1:0] C_START = CNT_W'(START_CYC);
    localparam logic [CNT_W-1:0] C_MASK  = CNT_W'(3);
    localparam logic [CNT_W-1:0] L_WAIT  = CNT_W'(RESP_WAIT_US * US_CYC - 1);
    localparam logic [CNT_W-1:0] L_RLOW  = CNT_W'(RESP_LOW_US * US_CYC - 1);
    localparam logic [CNT_W-1:0] L_RHIGH = CNT_W'(RESP_HIGH_US * US_CYC - 1);
    localparam logic [CNT_W-1:0] L_BLOW  = CNT_W'(BIT_LOW_US * US_CYC - 1);
    localparam logic [CNT_W-1:0] L_B0    = CNT_W'(BIT0_HIGH_US * US_CYC - 1);
    localparam logic [CNT_W-1:0] L_B1    = CNT_W'(BIT1_HIGH_US * US_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_WAIT, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_last_cnt;
    logic [1:0]       r_sync;
    logic [39:0]      r_word;
    logic [5:0]       r_idx;
    logic             r_oe, r_busy, r_done, r_abort;
    logic             w_ds, w_last, w_contend;
    logic             w_snap, w_idx_load, w_idx_dec, w_abort, w_done, w_oe, w_busy;
    logic [7:0]       w_csum;

    assign w_ds   = r_sync[1];
    assign w_csum = i_humidity_int + i_humidity_float + i_temperature_int + i_temperature_float;
    assign w_last = (r_cnt == w_last_cnt);
    assign w_oe   = (r_state == S_RESP_LOW) || (r_state == S_BIT_LOW) || (r_state == S_END_LOW);
    assign w_busy = (r_state != S_IDLE) && (r_state != S_HOST_LOW);

    // The first 3 cycles of a released phase still show our own low drive through the synchronizer.
    assign w_contend = ((r_state == S_WAIT) || (r_state == S_RESP_HIGH) || (r_state == S_BIT_HIGH))
                       && (r_cnt >= C_MASK) && !w_ds;

    always_comb begin
        w_last_cnt = '0;
        case (r_state)
            S_WAIT:              w_last_cnt = L_WAIT;
            S_RESP_LOW:          w_last_cnt = L_RLOW;
            S_RESP_HIGH:         w_last_cnt = L_RHIGH;
            S_BIT_LOW, S_END_LOW: w_last_cnt = L_BLOW;
            S_BIT_HIGH:          w_last_cnt = r_word[r_idx] ? L_B1 : L_B0;
            default:             w_last_cnt = '0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_snap     = 1'b0;
        w_idx_load = 1'b0;
        w_idx_dec  = 1'b0;
        w_abort    = 1'b0;
        w_done     = 1'b0;
        if (w_contend) begin
            w_next  = S_HOST_LOW;
            w_abort = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:      if (!w_ds) w_next = S_HOST_LOW;
                S_HOST_LOW: begin
                    if (w_ds) begin
                        if (r_cnt >= C_START) begin
                            w_next = S_WAIT;
                            w_snap = 1'b1;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
                S_WAIT:      if (w_last) w_next = S_RESP_LOW;
                S_RESP_LOW:  if (w_last) w_next = S_RESP_HIGH;
                S_RESP_HIGH: begin
                    if (w_last) begin
                        w_next     = S_BIT_LOW;
                        w_idx_load = 1'b1;
                    end
                end
                S_BIT_LOW:   if (w_last) w_next = S_BIT_HIGH;
                S_BIT_HIGH: begin
                    if (w_last) begin
                        if (r_idx == 6'd0) begin
                            w_next = S_END_LOW;
                        end else begin
                            w_next    = S_BIT_LOW;
                            w_idx_dec = 1'b1;
                        end
                    end
                end
                S_END_LOW: begin
                    if (w_last) begin
                        w_next = S_IDLE;
                        w_done = 1'b1;
                    end
                end
                default:     w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are the state decode registered once, so the line drive is glitch-free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sync  <= 2'b11;
            r_word  <= '0;
            r_idx   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_data_in};
            r_state <= w_next;
            if ((w_next != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else if ((r_state != S_HOST_LOW) || (r_cnt < C_START)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_snap) begin
                r_word <= {i_humidity_int, i_humidity_float, i_temperature_int, i_temperature_float, w_csum};
            end
            if (w_idx_load) begin
                r_idx <= 6'd39;
            end else if (w_idx_dec) begin
                r_idx <= r_idx - 1'b1;
            end
            r_oe    <= w_oe;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_abort <= w_abort;
        end
    end

    assign o_data_oe    = r_oe;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_abort      = r_abort;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb/tb_dht11_sensor_emu.sv - self-checking bench for dht11_sensor_emu
module tb_dht11_sensor_emu;

    localparam int US_CYC       = 1;
    localparam int START_MIN_US = 20;
    localparam int RESP_WAIT_US = 3;
    localparam int RESP_LOW_US  = 8;
    localparam int RESP_HIGH_US = 8;
    localparam int BIT_LOW_US   = 5;
    localparam int BIT0_HIGH_US = 2;
    localparam int BIT1_HIGH_US = 7;
    // 2-FF synchronizer + 1 decision cycle + wait phase + 1 output register stage
    localparam int EXP_LAT      = 2 + 1 + RESP_WAIT_US * US_CYC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] b0 = 8'h00, b1 = 8'h00, b2 = 8'h00, b3 = 8'h00;
    logic       data_in, data_oe, busy, frame_done, abort_p;
    int         n_pass = 0, n_total = 0, done_cnt = 0, abort_cnt = 0;

    assign data_in = !(data_oe || host_low);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (abort_p) abort_cnt++;
    end

    dht11_sensor_emu #(
        .US_CYC(US_CYC), .START_MIN_US(START_MIN_US), .RESP_WAIT_US(RESP_WAIT_US),
        .RESP_LOW_US(RESP_LOW_US), .RESP_HIGH_US(RESP_HIGH_US), .BIT_LOW_US(BIT_LOW_US),
        .BIT0_HIGH_US(BIT0_HIGH_US), .BIT1_HIGH_US(BIT1_HIGH_US)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .o_data_oe(data_oe),
        .i_humidity_int(b0), .i_humidity_float(b1), .i_temperature_int(b2), .i_temperature_float(b3),
        .o_busy(busy), .o_frame_done(frame_done), .o_abort(abort_p)
    );

    function automatic logic [39:0] frame_word(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d);
        int sum;
        sum = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        return {a, b, c, d, 8'(sum)};
    endfunction

    function automatic int high_len(input logic v);
        return v ? BIT1_HIGH_US * US_CYC : BIT0_HIGH_US * US_CYC;
    endfunction

    task automatic randomize_bytes();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (data_oe === lvl && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic host_start(input int low_cyc);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_cyc) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_oe_high(output int k);
        k = 0;
        while (data_oe !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Called right after the host releases the line; measures every phase of the response.
    task automatic capture_frame(input logic [39:0] exp, input bit scramble, output logic [39:0] got);
        int k, n, d0;
        d0 = done_cnt;
        got = '0;
        wait_oe_high(k);
        n_total++; if (k !== EXP_LAT) $display("FAIL latency: got %0d want %0d", k, EXP_LAT); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_in_frame: got %b want 1", busy); else n_pass++;
        if (scramble) randomize_bytes();
        run_len(1'b1, n);
        n_total++; if (n !== RESP_LOW_US * US_CYC) $display("FAIL resp_low: got %0d want %0d", n, RESP_LOW_US * US_CYC); else n_pass++;
        run_len(1'b0, n);
        n_total++; if (n !== RESP_HIGH_US * US_CYC) $display("FAIL resp_high: got %0d want %0d", n, RESP_HIGH_US * US_CYC); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            run_len(1'b1, n);
            n_total++; if (n !== BIT_LOW_US * US_CYC) $display("FAIL bit%0d_low: got %0d want %0d", i, n, BIT_LOW_US * US_CYC); else n_pass++;
            run_len(1'b0, n);
            n_total++; if (n !== high_len(exp[39-i])) $display("FAIL bit%0d_high: got %0d want %0d", i, n, high_len(exp[39-i])); else n_pass++;
            got[39-i] = (n > (BIT0_HIGH_US + BIT1_HIGH_US) * US_CYC / 2);
        end
        run_len(1'b1, n);
        n_total++; if (n !== BIT_LOW_US * US_CYC) $display("FAIL end_low: got %0d want %0d", n, BIT_LOW_US * US_CYC); else n_pass++;
        n_total++; if (got !== exp) $display("FAIL frame_bytes: got %h want %h", got, exp); else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL busy_after: got %b want 0", busy); else n_pass++;
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL frame_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (data_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", data_oe); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else n_pass++;
        n_total++; if (abort_p !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort_p); else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [39:0] got;
        b0 = 8'h37; b1 = 8'h00; b2 = 8'h19; b3 = 8'h00;
        host_start(25);
        capture_frame(frame_word(b0, b1, b2, b3), 1'b0, got);
        n_total++; if (got !== 40'h3700190050) $display("FAIL basic_word: got %h want 3700190050", got); else n_pass++;
    endtask

    task automatic test_checksum_wrap();
        logic [39:0] got;
        b0 = 8'hFF; b1 = 8'hFF; b2 = 8'h01; b3 = 8'h02;
        host_start(25);
        capture_frame(frame_word(b0, b1, b2, b3), 1'b0, got);
        n_total++; if (got[7:0] !== 8'h01) $display("FAIL csum_wrap: got %h want 01", got[7:0]); else n_pass++;
    endtask

    task automatic test_short_start();
        int len, a0, d0;
        logic seen_oe, seen_busy;
        for (int t = 0; t < 3; t++) begin
            len = (t == 0) ? 15 : int'($urandom_range(5, 17));
            a0 = abort_cnt; d0 = done_cnt;
            host_start(len);
            seen_oe = 1'b0; seen_busy = 1'b0;
            repeat (80) begin
                @(negedge clk);
                seen_oe   = seen_oe | data_oe;
                seen_busy = seen_busy | busy;
            end
            #1;
            n_total++; if (seen_oe !== 1'b0) $display("FAIL short_oe len=%0d: got %b want 0", len, seen_oe); else n_pass++;
            n_total++; if (seen_busy !== 1'b0) $display("FAIL short_busy len=%0d: got %b want 0", len, seen_busy); else n_pass++;
            n_total++; if ((abort_cnt - a0) + (done_cnt - d0) !== 0) $display("FAIL short_pulses len=%0d: got %0d want 0", len, (abort_cnt - a0) + (done_cnt - d0)); else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        logic [39:0] got;
        for (int f = 0; f < 3; f++) begin
            randomize_bytes();
            host_start(int'($urandom_range(22, 40)));
            capture_frame(frame_word(b0, b1, b2, b3), 1'b0, got);
        end
    endtask

    task automatic test_abort();
        int k, n, a0, d0;
        logic [39:0] got;
        randomize_bytes();
        b1 = b1 | 8'h20;    // transmitted bit 10 is a '1', giving a long released phase
        host_start(25);
        wait_oe_high(k);
        run_len(1'b1, n);
        run_len(1'b0, n);
        for (int i = 0; i < 10; i++) begin
            run_len(1'b1, n);
            run_len(1'b0, n);
        end
        run_len(1'b1, n);
        #1;
        a0 = abort_cnt; d0 = done_cnt;
        repeat (3) @(negedge clk);
        host_low = 1'b1;
        k = 0;
        while (abort_p !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_total++; if (abort_p !== 1'b1) $display("FAIL abort_pulse: got %b want 1", abort_p); else n_pass++;
        n_total++; if (data_oe !== 1'b0) $display("FAIL abort_oe: got %b want 0", data_oe); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        repeat (25) @(negedge clk);
        #1;
        n_total++; if (abort_cnt - a0 !== 1) $display("FAIL abort_count: got %0d want 1", abort_cnt - a0); else n_pass++;
        n_total++; if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); else n_pass++;
        host_low = 1'b0;
        capture_frame(frame_word(b0, b1, b2, b3), 1'b0, got);
    endtask

    task automatic test_reset_mid_frame();
        int k, n, d0;
        logic seen;
        for (int p = 0; p < 2; p++) begin
            randomize_bytes();
            host_start(25);
            wait_oe_high(k);
            if (p == 1) begin
                run_len(1'b1, n);
                run_len(1'b0, n);
            end
            @(negedge clk);
            d0 = done_cnt;
            n_total++; if (data_oe !== 1'b1) $display("FAIL rst%0d_pre_oe: got %b want 1", p, data_oe); else n_pass++;
            rst = 1'b1;
            @(negedge clk);
            n_total++; if (data_oe !== 1'b0) $display("FAIL rst%0d_oe: got %b want 0", p, data_oe); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL rst%0d_busy: got %b want 0", p, busy); else n_pass++;
            rst = 1'b0;
            seen = 1'b0;
            repeat (120) begin
                @(negedge clk);
                seen = seen | data_oe | frame_done;
            end
            #1;
            n_total++; if (seen !== 1'b0) $display("FAIL rst%0d_quiet: got %b want 0", p, seen); else n_pass++;
            n_total++; if (done_cnt !== d0) $display("FAIL rst%0d_no_done: got %0d want %0d", p, done_cnt, d0); else n_pass++;
        end
    endtask

    task automatic test_snapshot();
        logic [39:0] exp, got;
        randomize_bytes();
        exp = frame_word(b0, b1, b2, b3);
        host_start(30);
        capture_frame(exp, 1'b1, got);
    endtask

    task automatic test_back_to_back();
        logic [39:0] got;
        for (int f = 0; f < 2; f++) begin
            randomize_bytes();
            host_start(21 + f * 4);
            capture_frame(frame_word(b0, b1, b2, b3), 1'b0, got);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_checksum_wrap();
        test_short_start();
        test_random_frames();
        test_abort();
        test_reset_mid_frame();
        test_snapshot();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
